// File: rtl/axi_rr_txn_arbiter_if.sv
// Requester, slave address and status signals of the round-robin transaction arbiter.
// The master modport is the arbiter's view; slave is the environment (requesters + slave port).
interface axi_rr_txn_arbiter_if #(
  parameter int unsigned NB_MASTER  = 3,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned SRC_WIDTH = $clog2(NB_MASTER);

  logic [NB_MASTER-1:0]            req_valid_i;
  logic [NB_MASTER-1:0]            req_ready_o;
  logic [NB_MASTER*ADDR_WIDTH-1:0] req_addr_i;
  logic [NB_MASTER-1:0]            req_write_i;
  logic                            m_valid_o;
  logic                            m_ready_i;
  logic [ADDR_WIDTH-1:0]           m_addr_o;
  logic                            m_write_o;
  logic [SRC_WIDTH-1:0]            m_src_o;
  logic                            rsp_done_i;
  logic [NB_MASTER-1:0]            grant_o;
  logic                            busy_o;
  logic                            timeout_o;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, m_ready_i, rsp_done_i,
    output req_ready_o, m_valid_o, m_addr_o, m_write_o, m_src_o, grant_o, busy_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, m_ready_i, rsp_done_i,
    input  req_ready_o, m_valid_o, m_addr_o, m_write_o, m_src_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/axi_rr_txn_arbiter.sv
// Round-robin, single-outstanding arbiter sharing one AXI address channel between NB_MASTER
// requesters. Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module axi_rr_txn_arbiter #(
  parameter int unsigned NB_MASTER      = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst_n,
  axi_rr_txn_arbiter_if.master bus
);
  localparam int unsigned SRC_WIDTH = $clog2(NB_MASTER);

  if (NB_MASTER < 2 || NB_MASTER > 8) begin : g_bad_nb_master
    $error("NB_MASTER must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StAddr, StWaitRsp} state_e;

  state_e                state_q, state_d;
  logic [SRC_WIDTH-1:0]  ptr_q;
  logic [SRC_WIDTH-1:0]  src_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [NB_MASTER-1:0]  grant_q;
  logic [SRC_WIDTH-1:0]  win;
  logic                  any_req;
  logic                  accept;
  logic                  expire;
  logic                  finish;
  logic [SRC_WIDTH-1:0]  ptr_next;

  // First requester at or above the pointer, wrapping modulo NB_MASTER.
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NB_MASTER; i++) begin
      if (!any_req && bus.req_valid_i[(32'(ptr_q) + i) % NB_MASTER]) begin
        win     = SRC_WIDTH'((32'(ptr_q) + i) % NB_MASTER);
        any_req = 1'b1;
      end
    end
  end

  assign accept   = (state_q == StIdle) && any_req;
  assign finish   = (state_q == StWaitRsp) && (bus.rsp_done_i || expire);
  assign ptr_next = (src_q == SRC_WIDTH'(NB_MASTER - 1)) ? '0 : src_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (any_req) state_d = StAddr;
      StAddr:    if (bus.m_ready_i) state_d = StWaitRsp;
      StWaitRsp: if (bus.rsp_done_i || expire) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_ready_o = '0;
    bus.m_valid_o   = 1'b0;
    bus.busy_o      = 1'b0;
    unique case (state_q)
      StIdle:    if (any_req) bus.req_ready_o[win] = 1'b1;
      StAddr: begin
        bus.m_valid_o = 1'b1;
        bus.busy_o    = 1'b1;
      end
      StWaitRsp: bus.busy_o = 1'b1;
      default:   ;
    endcase
  end

  // Captured request stays stable for the whole transaction; grant drops on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      src_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr_i[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      write_q <= bus.req_write_i[win];
      src_q   <= win;
      grant_q <= NB_MASTER'(1) << win;
    end else if (finish) begin
      grant_q <= '0;
      ptr_q   <= ptr_next;
    end
  end

  assign bus.m_addr_o  = addr_q;
  assign bus.m_write_o = write_q;
  assign bus.m_src_o   = src_q;
  assign bus.grant_o   = grant_q;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 timeout_q;

  // rsp_done_i in the expiry cycle wins, so it completes normally without a pulse.
  assign expire = (state_q == StWaitRsp) && !bus.rsp_done_i &&
                  (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StAddr && bus.m_ready_i) begin
      cnt_d = '0;
    end else if (state_q == StWaitRsp) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= expire;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign expire        = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif

endmodule
